// File: rtl/cache_mem_ctrl.sv
// Memory-side controller for a cache: accepts one read or write request at a
// time, answers after a fixed latency with a one-cycle data_ready pulse, and
// spends one HOLD cycle afterwards so the cache can drop its request.
module cache_mem_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 16384,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_address,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic              mrden,
  input  logic              mwren,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              data_ready,
  output logic              busy
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              data_ready_q, data_ready_d;
  logic              busy_q, busy_d;

  logic [31:0]       mem [DEPTH];

  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              unused_addr_bits;

  // Word index is the byte address without its two low bits, wrapped to DEPTH.
  assign rd_idx           = IDX_W'(rd_address[ADDR_W-1:2]);
  assign wr_idx           = IDX_W'(wr_address[ADDR_W-1:2]);
  assign unused_addr_bits = ^{rd_address[1:0], wr_address[1:0]};

  assign rd_data    = rd_data_q;
  assign data_ready = data_ready_q;
  assign busy       = busy_q;

  // Next-state and output decode; outputs are computed for the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_wr_d      = op_wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rd_data_d    = rd_data_q;
    data_ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mwren || mrden) begin
          op_wr_d = mwren;
          idx_d   = mwren ? wr_idx : rd_idx;
          wdata_d = wr_data;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            // Single-cycle latency: the read word is fetched on the acceptance edge.
            state_d      = RESP;
            data_ready_d = 1'b1;
            if (!mwren) rd_data_d = mem[rd_idx];
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d      = RESP;
          data_ready_d = 1'b1;
          if (!op_wr_q) rd_data_d = mem[idx_q];
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_wr_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      data_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_wr_q      <= op_wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      data_ready_q <= data_ready_d;
      busy_q       <= busy_d;
    end
  end

  // Storage array: written on the RESP->HOLD edge of a write, never cleared.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && op_wr_q) mem[idx_q] <= wdata_q;
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: one instance with LATENCY=4/DEPTH=16384
// and one with LATENCY=1/DEPTH=1024, driven by a vector table plus
// hand-written multi-cycle sequences.
module tb_cache_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] a_rd_addr = '0, a_wr_addr = '0, b_rd_addr = '0, b_wr_addr = '0;
  logic        a_mrden = 1'b0, a_mwren = 1'b0, b_mrden = 1'b0, b_mwren = 1'b0;
  logic [31:0] a_wr_data = '0, b_wr_data = '0;
  logic [31:0] a_rd_data, b_rd_data;
  logic        a_dr, b_dr, a_busy, b_busy;

  int n_cmp  = 0;
  int n_fail = 0;

  cache_mem_ctrl #(.ADDR_W(16), .DEPTH(16384), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst), .rd_address(a_rd_addr), .wr_address(a_wr_addr),
    .mrden(a_mrden), .mwren(a_mwren), .wr_data(a_wr_data),
    .rd_data(a_rd_data), .data_ready(a_dr), .busy(a_busy)
  );

  cache_mem_ctrl #(.ADDR_W(16), .DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .rd_address(b_rd_addr), .wr_address(b_wr_addr),
    .mrden(b_mrden), .mwren(b_mwren), .wr_data(b_wr_data),
    .rd_data(b_rd_data), .data_ready(b_dr), .busy(b_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic we, input logic re,
                       input logic [15:0] ra, input logic [15:0] wa, input logic [31:0] wd);
    if (which == 0) begin
      a_mwren = we; a_mrden = re; a_rd_addr = ra; a_wr_addr = wa; a_wr_data = wd;
    end else begin
      b_mwren = we; b_mrden = re; b_rd_addr = ra; b_wr_addr = wa; b_wr_data = wd;
    end
  endtask

  function automatic logic get_dr(input int which);
    return (which == 0) ? a_dr : b_dr;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? a_busy : b_busy;
  endfunction

  function automatic logic [31:0] get_rd(input int which);
    return (which == 0) ? a_rd_data : b_rd_data;
  endfunction

  // Steps until data_ready is seen; lat is the edge count, or -1 on timeout.
  task automatic wait_dr(input int which, output int lat);
    lat = -1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      step();
      if (get_dr(which)) lat = n;
    end
  endtask

  // One complete transaction, request dropped right after data_ready.
  task automatic txn(input string tag, input int which, input logic we, input logic [15:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    drive(which, we, !we, addr, addr, wd);
    wait_dr(which, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rd"}, get_rd(which), exp_rd);
    drive(which, 1'b0, 1'b0, addr, addr, wd);
    step();
    check({tag, "_pulse"}, 32'(get_dr(which)), 32'd0);
    check({tag, "_hold_busy"}, 32'(get_busy(which)), 32'd1);
    step();
    check({tag, "_idle_busy"}, 32'(get_busy(which)), 32'd0);
  endtask

  function automatic void add(input int dut, input logic we, input logic [15:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat);
    vec_t v;
    v.dut = dut; v.we = we; v.addr = addr; v.wd = wd; v.exp_rd = exp_rd; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endfunction

  initial begin
    int lat;
    int dr_seen;

    // dut, we, addr, wdata, expected rd_data at data_ready, expected latency
    add(0, 1'b1, 16'h0404, 32'hDEADBEEF, 32'h00000000, 4);
    add(0, 1'b0, 16'h0404, 32'h0,        32'hDEADBEEF, 4);
    add(0, 1'b1, 16'h1000, 32'h22222222, 32'hDEADBEEF, 4);
    add(0, 1'b0, 16'h1000, 32'h0,        32'h22222222, 4);
    add(0, 1'b0, 16'h0407, 32'h0,        32'hDEADBEEF, 4);
    add(0, 1'b1, 16'hFFFC, 32'h0BADF00D, 32'hDEADBEEF, 4);
    add(0, 1'b0, 16'hFFFF, 32'h0,        32'h0BADF00D, 4);
    add(0, 1'b1, 16'h0000, 32'h13579BDF, 32'h0BADF00D, 4);
    add(0, 1'b0, 16'h0002, 32'h0,        32'h13579BDF, 4);
    add(1, 1'b1, 16'hFFFC, 32'hCAFEF00D, 32'h00000000, 1);
    add(1, 1'b0, 16'hFFFC, 32'h0,        32'hCAFEF00D, 1);
    add(1, 1'b0, 16'h0FFC, 32'h0,        32'hCAFEF00D, 1);
    add(1, 1'b1, 16'h1000, 32'h00001111, 32'hCAFEF00D, 1);
    add(1, 1'b0, 16'h0000, 32'h0,        32'h00001111, 1);
    add(1, 1'b0, 16'h1FFE, 32'h0,        32'hCAFEF00D, 1);

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_a_rd", a_rd_data, 32'h0);
    check("rst_a_dr", 32'(a_dr), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_b_rd", b_rd_data, 32'h0);
    check("rst_b_busy", 32'(b_busy), 32'd0);

    foreach (vecs[i])
      txn($sformatf("vec%0d", i), vecs[i].dut, vecs[i].we, vecs[i].addr, vecs[i].wd,
          vecs[i].exp_rd, vecs[i].exp_lat);

    // Reset must clear outputs but keep the array contents.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_a_rd", a_rd_data, 32'h0);
    check("rst2_b_rd", b_rd_data, 32'h0);
    check("rst2_a_busy", 32'(a_busy), 32'd0);
    txn("keep_a", 0, 1'b0, 16'h0404, 32'h0, 32'hDEADBEEF, 4);
    txn("keep_b", 1, 1'b0, 16'h0000, 32'h0, 32'h00001111, 1);

    // Both requests in IDLE: write first, read accepted after HOLD and IDLE.
    drive(0, 1'b1, 1'b1, 16'h2000, 16'h2000, 32'hA5A5A5A5);
    wait_dr(0, lat);
    check("simul_wr_lat", 32'(lat), 32'd4);
    check("simul_wr_rd_kept", a_rd_data, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b1, 16'h2000, 16'h2000, 32'hA5A5A5A5);
    wait_dr(0, lat);
    check("simul_rd_gap", 32'(lat), 32'd6);
    check("simul_rd_data", a_rd_data, 32'hA5A5A5A5);
    drive(0, 1'b0, 1'b0, 16'h2000, 16'h2000, 32'h0);
    step();
    step();

    // Read request held through HOLD: ignored there, re-accepted in IDLE.
    drive(0, 1'b0, 1'b1, 16'h0404, 16'h0404, 32'h0);
    wait_dr(0, lat);
    check("held_first_lat", 32'(lat), 32'd4);
    check("held_first_rd", a_rd_data, 32'hDEADBEEF);
    step();
    check("held_hold_dr", 32'(a_dr), 32'd0);
    check("held_hold_busy", 32'(a_busy), 32'd1);
    step();
    check("held_idle_busy", 32'(a_busy), 32'd0);
    step();
    check("held_reaccept_busy", 32'(a_busy), 32'd1);
    wait_dr(0, lat);
    check("held_second_lat", 32'(lat), 32'd3);
    drive(0, 1'b0, 1'b0, 16'h0404, 16'h0404, 32'h0);
    step();
    step();

    // Reset during WAIT of a write: no completion, word untouched.
    drive(0, 1'b1, 1'b0, 16'h0404, 16'h0404, 32'h11111111);
    step();
    step();
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0404, 16'h0404, 32'h0);
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(a_busy), 32'd0);
    check("midrst_dr", 32'(a_dr), 32'd0);
    check("midrst_rd", a_rd_data, 32'h0);
    dr_seen = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (a_dr) dr_seen++;
    end
    check("midrst_no_dr", 32'(dr_seen), 32'd0);
    txn("midrst_word", 0, 1'b0, 16'h0404, 32'h0, 32'hDEADBEEF, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
